// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: select generator and capture stage for an 8:1 mux.
// The block steps the mux select round-robin over the enabled channels. After
// each select change it waits DWELL cycles, then captures the mux output and
// offers it, tagged with its channel number, on a valid/ready port.
module mux_scan_ctrl #(
    parameter int N_CH  = 8,
    parameter int DW    = 3,
    parameter int DWELL = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_CH-1:0]  mask,
    input  logic [DW-1:0]    y_in,
    output logic [SEL_W-1:0] s,
    output logic [DW-1:0]    out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_s;

    // Circular priority scan: first set bit of m at or after 'start', wrapping.
    // If m is empty the start index is returned unchanged (callers gate on |m).
    function automatic logic [SEL_W-1:0] find_chan(input logic [N_CH-1:0]  m,
                                                   input logic [SEL_W-1:0] start);
        logic [SEL_W-1:0] res;
        logic [SEL_W-1:0] idx;
        logic             found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = SEL_W'((int'(start) + i) % N_CH);
            if (!found && m[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    // State register plus the registered select, dwell counter and output port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_q         <= {SEL_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_data_q  <= {DW{1'b0}};
            out_ch_q    <= {SEL_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic: channel selection, dwell countdown, capture, handshake.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                // Leaving idle re-checks the current channel first (inclusive).
                if (en && (|mask)) begin
                    s_d     = find_chan(mask, s_q);
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // A started dwell always completes; en and mask are not looked at.
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    out_data_d  = y_in;
                    out_ch_d    = s_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (en && (|mask)) begin
                        // Search strictly after s; a lone enabled channel maps to itself.
                        s_d     = find_chan(mask, SEL_W'((int'(s_q) + 1) % N_CH));
                        cnt_d   = CNT_LOAD;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Output decode: busy whenever a scan step is in progress.
    always_comb begin
        busy_s = 1'b0;
        if (state_q != ST_IDLE) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    assign s         = s_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_s;

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Select-generator and capture stage that sits directly upstream of the 8:1 3-bit mux.
- Drives the mux select `s` round-robin over a maskable set of channels.
- Waits a programmable settle (dwell) time after each select change.
- Captures the mux output `y` and presents it, tagged with its channel number, on a valid/ready output port.

Parameters:
- N_CH, 8, number of mux channels (select width SEL_W = clog2(N_CH) = 3).
- DW, 3, data width of the mux output.
- DWELL, 4, number of cycles `s` is held stable before `y_in` is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  scan enable; level-sensitive.
- mask  input  N_CH  channel enable; bit i = 1 includes channel i in the scan.
- y_in  input  DW  mux output (mux `y`).
- s  output  SEL_W  mux select (drives mux `s`); registered.
- out_data  output  DW  captured sample.
- out_ch  output  SEL_W  channel number of `out_data`.
- out_valid  output  1  sample available.
- out_ready  input  1  consumer accepts the sample.
- busy  output  1  high in any state except IDLE.

Behaviour:
Reset values (reset is synchronous and overrides everything; it aborts any pending sample):
- s = 0, out_data = 0, out_ch = 0, out_valid = 0, busy = 0, dwell counter = 0, state = IDLE.

State machine (states IDLE, SETTLE, HOLD):
- IDLE:
  - If en = 1 and mask != 0: s <= first enabled channel searching circularly from the current s, with s itself included. Load the dwell counter with DWELL-1 and go to SETTLE.
  - Otherwise stay in IDLE with s unchanged.
- SETTLE:
  - While the counter != 0, decrement it.
  - When the counter == 0: out_data <= y_in, out_ch <= s, out_valid <= 1, go to HOLD.
  - en and mask are ignored in SETTLE; a started dwell always completes.
- HOLD:
  - out_valid, out_data, out_ch and s are held stable until out_valid & out_ready at a clock edge.
  - At that edge out_valid <= 0, then:
    - if en = 1 and mask != 0: s <= next enabled channel strictly after s, circular (wraps 7 -> 0); reload the counter with DWELL-1 and go to SETTLE. If s is the only enabled channel, s stays the same and a new dwell still starts.
    - otherwise go to IDLE with s unchanged.

Timing:
- If s changes at edge k, y_in is sampled and out_valid rises at edge k+DWELL. This gives exactly DWELL cycles of stable s before sampling.
- With out_ready held at 1, the handshake completes at edge k+DWELL+1, and s advances at that same edge. The per-channel period is therefore DWELL+1 cycles.

Other rules:
- mask is sampled only when choosing a channel (leaving IDLE, or at a HOLD handshake). A mask change mid-dwell does not cancel the current sample, even if the current channel was just masked off.
- out_valid never drops without a handshake, except on reset.
- The next-channel search is a combinational circular priority scan over mask, starting at s+1 (or at s when leaving IDLE), modulo N_CH.
- busy = (state != IDLE).

Test Plan:
The bench models the mux with d_i = i, so y_in = s.

1. mask=8'hFF, en=1, out_ready=1, DWELL=4, from reset:
   - s steps 0,1,...,7,0 with a 5-cycle period.
   - Each accepted beat has out_ch = out_data = the channel index.
   - First out_valid occurs 5 cycles after en rises.
2. mask=8'b1010_0100, same setup:
   - Accepted channels in order are 2,5,7,2,5.
   - s never takes a masked value after the first selection.
3. Backpressure:
   - Hold out_ready=0 for 10 cycles while in HOLD on channel 3: out_valid stays 1, and out_data=3, out_ch=3, s=3 stay constant.
   - Raise out_ready: exactly one beat is accepted and s goes to 4.
4. Disable mid-operation:
   - Drop en during SETTLE on channel 6: the sample still appears (out_ch=6).
   - After the handshake, state is IDLE, busy=0, s stays 6.
   - Re-raise en: s stays 6 (inclusive search) and the next sample is channel 6.
5. Degenerate masks:
   - mask=0, en=1: busy stays 0 and out_valid stays 0 indefinitely.
   - mask=8'b0001_0000: s stays 4 and a beat is produced every DWELL+1 cycles.
6. Reset mid-HOLD with out_valid=1 on channel 5:
   - After the reset edge: out_valid=0, s=0, out_ch=0, out_data=0, busy=0.
   - After reset is released with en=1 and mask=8'hFF: the scan restarts at channel 0.
